// File: rtl/store_checker_pkg.sv
// Shared types and width helpers for the store-bus checker.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // Bits needed to hold the values 0..n inclusive (idx, count and timer counters).
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to address n table slots.
  function automatic int index_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// Expected-store table: appended by count, read asynchronously at the checker's idx.
module expect_table
  import store_checker_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam int AW = index_width(DEPTH);

  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] entry_reg [DEPTH];

  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (wr_en && !full) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Contents are not cleared on reset: a zero count already makes every slot unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      entry_reg[count_reg[AW-1:0]] <= {wr_addr, wr_data};
    end
  end

  // idx reaches DEPTH once a full table has passed, so guard the out-of-range read.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (rd_idx < CW'(DEPTH)) begin
      {rd_addr, rd_data} = entry_reg[rd_idx[AW-1:0]];
    end
  end

endmodule

// File: rtl/store_checker.sv
// Monitors the processor store bus against a loaded table of expected stores, in order,
// with a per-step timeout; status is sticky until clr or reset.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int LENIENT = 0,
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             arm,
  input  logic             clr,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CW-1:0]    match_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam int TW = count_width(TIMEOUT);

  state_t           state_reg, state_next;
  logic [CW-1:0]    idx_reg, idx_inc, count;
  logic [TW-1:0]    timer_reg;
  logic             timeout_reg;
  logic [WIDTH-1:0] fail_addr_reg, fail_data_reg;
  logic [WIDTH-1:0] exp_addr, exp_data;
  logic             full, load_ok, arm_ok;
  logic             addr_hit, data_hit, stray, last, expire;

  expect_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .srst    (reset),
    .wr_en   (load_ok),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_idx  (idx_reg),
    .rd_addr (exp_addr),
    .rd_data (exp_data),
    .count   (count),
    .full    (full)
  );

  assign load_ok  = (state_reg == IDLE) && load_en && !clr && !full;
  // A load in the arming cycle makes an empty table non-empty in time.
  assign arm_ok   = arm && ((count != '0) || load_en);
  assign idx_inc  = idx_reg + CW'(1);
  assign addr_hit = memwrite && (dataadr == exp_addr);
  assign data_hit = addr_hit && (writedata == exp_data);
  assign stray    = memwrite && !addr_hit && (LENIENT == 0);
  assign last     = (idx_inc == count);
  assign expire   = (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (arm_ok) state_next = RUN;
        RUN: begin
          if (data_hit) begin
            if (last) state_next = PASS;
          end else if (addr_hit || stray || expire) begin
            state_next = FAIL;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    pass = 1'b0;
    fail = 1'b0;
    case (state_reg)
      PASS:    pass = 1'b1;
      FAIL:    fail = 1'b1;
      default: ;
    endcase
  end

  assign done        = pass | fail;
  assign timeout     = timeout_reg;
  assign match_count = idx_reg;
  assign fail_addr   = fail_addr_reg;
  assign fail_data   = fail_data_reg;

  // A match outranks timer expiry in the same cycle, so it is tested first.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      idx_reg       <= '0;
      timer_reg     <= '0;
      timeout_reg   <= 1'b0;
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (arm_ok) begin
        idx_reg   <= '0;
        timer_reg <= '0;
      end
    end else if (state_reg == RUN) begin
      if (data_hit) begin
        idx_reg   <= idx_inc;
        timer_reg <= '0;
      end else if (addr_hit || stray) begin
        fail_addr_reg <= dataadr;
        fail_data_reg <= writedata;
      end else if (expire) begin
        timeout_reg <= 1'b1;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
Synthesizable self-checking monitor for the processor store bus (memwrite, dataadr, writedata) of the top-level processor.
- Replaces a single hard-coded "one write at one address" check with a loadable table of up to DEPTH expected stores, checked in order.
- Adds a timeout and an optional lenient mode that ignores stray writes.
- Sits beside `top` in simulation or on an FPGA; reports pass/fail through sticky status outputs.

Parameters:
WIDTH, 32, data and address width of the store bus
DEPTH, 8, maximum number of expected stores in the table
TIMEOUT, 1000, maximum cycles allowed between arm/last match and the next match
LENIENT, 0, 0 = any non-matching write fails; 1 = writes whose address differs from the expected address are ignored

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high; clears everything including the table
memwrite  in  1  store strobe from the processor
dataadr  in  WIDTH  store address
writedata  in  WIDTH  store data
load_en  in  1  append (load_addr, load_data) to the table
load_addr  in  WIDTH  expected address
load_data  in  WIDTH  expected data
arm  in  1  start checking
clr  in  1  return to IDLE; keep the table, reset progress
done  out  1  PASS or FAIL reached
pass  out  1  all expected stores matched
fail  out  1  mismatch or timeout
timeout  out  1  the fail was caused by the timeout
match_count  out  $clog2(DEPTH+1)  number of expected stores matched so far
fail_addr  out  WIDTH  dataadr of the offending write (0 on timeout)
fail_data  out  WIDTH  writedata of the offending write (0 on timeout)

Behaviour:
- Reset values:
  - state = IDLE
  - table count = 0, idx = 0, timer = 0
  - all outputs 0
- States: IDLE, RUN, PASS, FAIL. done = (PASS|FAIL); pass/fail decoded from state, registered.
- IDLE:
  - load_en with count<DEPTH writes entry[count] and increments count.
  - load_en with count==DEPTH is ignored; the table is unchanged.
  - arm with count>0 (count includes a same-cycle load) -> RUN; idx=0, timer=0.
  - arm with count==0 is ignored.
- RUN (memwrite sampled at the rising edge):
  - memwrite, dataadr==entry[idx].addr and writedata==entry[idx].data: match.
    - idx increments and timer clears.
    - If idx was count-1 -> PASS.
  - memwrite, address matches, data differs -> FAIL; capture fail_addr/fail_data.
  - memwrite, address differs:
    - LENIENT=0 -> FAIL with capture.
    - LENIENT=1 -> ignored; timer is not cleared.
  - No match this cycle: timer increments. When timer reaches TIMEOUT-1 -> FAIL with timeout=1, fail_addr=fail_data=0.
  - A match in the same cycle as timer expiry wins: the match is taken, no timeout.
  - load_en and arm are ignored in RUN.
- PASS/FAIL are sticky. Only clr or reset leaves them.
- clr in any state -> IDLE:
  - idx=0, timer=0; status outputs and fail capture cleared.
  - Table and count are kept, so re-arming reruns the same sequence.
- Reset has priority over clr; clr has priority over every other input. Reset mid-RUN aborts with no status.
- match_count = idx, valid in every state.
- Latency: status appears the cycle after the deciding write.

Decomposition:
- Package store_checker_pkg:
  - state enum (IDLE, RUN, PASS, FAIL)
  - width helper constants for the idx and timer counters (timer width = $clog2(TIMEOUT+1))
- Sub-module expect_table:
  - DEPTH x (2*WIDTH) register file
  - one synchronous write port indexed by count
  - one asynchronous read port indexed by idx
  - owns count and exposes full

Test Plan:
1. Load {0x8054,1}, arm, drive memwrite addr 0x8054 data 1 -> next cycle pass=1, done=1, match_count=1.
2. Load {0x50,7},{0x54,7}, arm, write 0x50/7 then 0x54/8 -> fail=1, timeout=0, fail_addr=0x54, fail_data=8, match_count=1.
3. LENIENT=1: load {0x54,7}, arm, write 0x50/3 then 0x54/7 -> pass=1. Same stimulus with LENIENT=0 -> fail, fail_addr=0x50.
4. TIMEOUT=16: load one entry, arm, no writes -> fail=1 and timeout=1 exactly 16 cycles after arm. A matching write on cycle 16 -> pass instead.
5. Load 9 entries with DEPTH=8 -> count stays 8. arm with an empty table (after reset) stays IDLE, done=0.
6. After PASS, assert clr then arm, replay the same writes -> pass again. Assert reset mid-RUN -> all outputs 0, the next arm is ignored (table empty).
